rx_sample_fifo: RTL and testbench
=================================

// Module: rx_sample_fifo
// PURPOSE
//  Byte FIFO storing thermostat samples received over UART; sits directly downstream of the slave FSM.
//  The FSM issues single-cycle insert/remove/clear strobes; this block stores/returns bytes and reports
//  empty back to the FSM. UART RX byte feeds data_in; data_out goes to the temperature logic.
// PARAMETERS
//  DATA_W   8    width of one stored sample (UART byte)
//  DEPTH    16   number of entries; power of two, >= 2
//  ADDR_W   $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk         in   1         system clock, all logic on rising edge
//  rst         in   1         synchronous, active-low reset
//  insert      in   1         write strobe from FSM; captures data_in
//  remove      in   1         read strobe from FSM; pops oldest entry
//  clear       in   1         flush strobe from FSM; discards all contents
//  data_in     in   DATA_W    byte from UART RX, valid when insert=1
//  data_out    out  DATA_W    last popped byte, held until next pop
//  data_valid  out  1         1-cycle pulse: data_out updated this cycle
//  empty       out  1         count==0
//  full        out  1         count==DEPTH
//  count       out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow    out  1         1-cycle pulse: insert dropped (full, no pop)
//  underflow   out  1         1-cycle pulse: remove ignored (empty)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): wr_ptr=rd_ptr=0, count=0, data_out=0, data_valid=0, overflow=0,
//    underflow=0 -> empty=1, full=0. RAM contents not reset. Reset wins over every strobe.
//  - empty/full derived combinationally from registered count; reflect state after each edge.
//  - Priority: clear > insert/remove. clear: pointers=0, count=0 next cycle; insert/remove same
//    cycle ignored, no overflow/underflow pulse; data_out keeps old value, data_valid=0.
//  - Insert only, not full: mem[wr_ptr]<=data_in, wr_ptr+1 (wraps DEPTH-1 -> 0), count+1.
//  - Insert only, full: dropped, overflow=1 for one cycle, state unchanged.
//  - Remove only, not empty: data_out<=mem[rd_ptr], data_valid=1 next cycle (latency 1), rd_ptr+1 wraps.
//  - Remove only, empty: underflow=1 for one cycle, data_out held, data_valid=0.
//  - Insert+remove, 0<count<DEPTH: both performed, count unchanged.
//  - Insert+remove, empty: insert performed, remove -> underflow pulse (no bypass of data_in).
//  - Insert+remove, full: read of mem[rd_ptr] precedes write to same slot; both performed, count=DEPTH.
//  - Pointer arithmetic modulo DEPTH; count never exceeds DEPTH nor goes below 0.
// CONFIGURATION
//  RX_FIFO_OVERWRITE_EN defined: insert when full and no remove overwrites oldest entry:
//    mem[wr_ptr]<=data_in, wr_ptr+1, rd_ptr+1, count stays DEPTH; overflow still pulses (data lost).
//  Not defined: insert when full is dropped as above.
// STRUCTURE
//  - Shared package thermo_pkg: SAMPLE_W (=8), RX_FIFO_DEPTH (=16) constants, sample_t typedef.
//  - One sub-module: fifo_dpram (DEPTH x DATA_W, one sync write port, one sync read port, no reset).
//  - Top holds pointers, count, strobe decode, status pulses.
// TESTING
//  1 Reset: rst=0 2 cycles with insert=1 -> count=0, empty=1, data_valid=0, no write.
//  2 Insert 0x11,0x22,0x33 then 3 removes -> data_out 0x11,0x22,0x33 each 1 cycle after strobe,
//    data_valid pulses 3x, empty=1 after last.
//  3 Fill DEPTH=16 (0x00..0x0F), full=1; insert 0xAA -> overflow pulse, count=16; drain reads
//    0x00..0x0F (with RX_FIFO_OVERWRITE_EN: reads 0x01..0x0F,0xAA).
//  4 Remove on empty -> underflow pulse, data_out unchanged; insert+remove on empty -> count=1.
//  5 Wrap: 12 inserts/12 removes, then 10 inserts -> pointers wrap, order preserved; insert+remove
//    at count=16 -> count stays 16, popped byte is oldest.
//  6 clear with insert+remove at count=5 -> count=0 next cycle, empty=1, no pulses.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared thermostat constants and the sample type used by the UART receive path.
package thermo_pkg;

  localparam int SAMPLE_W      = 8;
  localparam int RX_FIFO_DEPTH = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/rx_sample_fifo_if.sv
// Strobe/status bundle between the slave FSM (master) and the sample FIFO (slave).
//
// Handshake: insert, remove and clear are single-cycle strobes sampled on the
// rising edge; there is no ready. The FIFO answers through status: data_valid
// pulses in the cycle after an accepted remove, with data_out holding the popped
// byte until the next accepted remove; overflow/underflow pulse for one cycle
// when a strobe could not be honoured. empty/full/count always describe the
// occupancy left by the most recent edge.
interface rx_sample_fifo_if
  import thermo_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = RX_FIFO_DEPTH
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              insert;
  logic              remove;
  logic              clear;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output insert, remove, clear, data_in,
    input  data_out, data_valid, empty, full, count, overflow, underflow
  );

  modport slave (
    input  insert, remove, clear, data_in,
    output data_out, data_valid, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port,
// no reset. A read and a write to the same address in one cycle return the old
// contents (read happens before write).
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming byte when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output, held while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_sample_fifo.sv
// Byte FIFO for thermostat samples received over UART.
// Holds pointers, occupancy count, strobe decode and the one-cycle status pulses;
// storage lives in fifo_dpram.
// Build option: define RX_FIFO_OVERWRITE_EN to make an insert into a full FIFO
// (without a simultaneous remove) replace the oldest entry instead of being dropped.
module rx_sample_fifo
  import thermo_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = RX_FIFO_DEPTH
) (
  input logic              clk,
  input logic              rst,
  rx_sample_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              data_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              popped_q;
  logic [DATA_W-1:0] ram_q;

  logic empty;
  logic full;
  logic do_ins;
  logic do_rem;
  logic wr_en;
  logic rd_en;
  logic ow_adv;
  logic rd_adv;
  logic overflow_nxt;
  logic underflow_nxt;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Strobe decode: clear masks insert/remove; reset masks everything so the RAM
  // is never written while rst is low.
  always_comb begin
    do_ins        = rst && !bus.clear && bus.insert;
    do_rem        = rst && !bus.clear && bus.remove;
    rd_en         = do_rem && !empty;
    underflow_nxt = do_rem && empty;
    overflow_nxt  = do_ins && full && !do_rem;
`ifdef RX_FIFO_OVERWRITE_EN
    wr_en         = do_ins;
    ow_adv        = do_ins && full && !do_rem;
`else
    wr_en         = do_ins && (!full || do_rem);
    ow_adv        = 1'b0;
`endif
    rd_adv        = rd_en || ow_adv;
  end

  // Next occupancy: net change of one write and one read-pointer advance.
  always_comb begin
    count_nxt = count_q;
    if (rst && bus.clear) begin
      count_nxt = '0;
    end else begin
      case ({wr_en, rd_adv})
        2'b10:   count_nxt = count_q + CNT_W'(1);
        2'b01:   count_nxt = count_q - CNT_W'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Pointer, count and status-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      popped_q     <= 1'b0;
    end else begin
      count_q      <= count_nxt;
      data_valid_q <= rd_en;
      overflow_q   <= overflow_nxt;
      underflow_q  <= underflow_nxt;
      if (rd_en) popped_q <= 1'b1;
      if (bus.clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + ADDR_W'(1);
        if (rd_adv) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // The RAM read register has no reset, so data_out reads as zero until the first pop.
  assign bus.data_out   = popped_q ? ram_q : '0;
  assign bus.data_valid = data_valid_q;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Directed testbench for rx_sample_fifo: reset, ordering, full/overflow,
// empty/underflow, pointer wrap and clear priority.
module tb_rx_sample_fifo;
  import thermo_pkg::*;

  localparam int W = SAMPLE_W;
  localparam int D = RX_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rx_sample_fifo_if #(.DATA_W(W), .DEPTH(D)) bus ();

  rx_sample_fifo #(.DATA_W(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] b);
    bus.insert  = 1'b1;
    bus.data_in = b;
    tick();
    bus.insert  = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic pop_chk(input string tag);
    logic [W-1:0] e;
    bus.remove = 1'b1;
    tick();
    bus.remove = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_model_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      last_out = e;
      check({tag, "_valid"}, 32'(bus.data_valid), 32'd1);
      check({tag, "_data"},  32'(bus.data_out),   32'(e));
    end
  endtask

  initial begin
    bus.insert  = 1'b0;
    bus.remove  = 1'b0;
    bus.clear   = 1'b0;
    bus.data_in = '0;

    // 1: reset holds off an insert strobe
    rst = 1'b0;
    bus.insert  = 1'b1;
    bus.data_in = 8'h5A;
    tick();
    tick();
    check("rst_count", 32'(bus.count),      32'd0);
    check("rst_empty", 32'(bus.empty),      32'd1);
    check("rst_full",  32'(bus.full),       32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_dout",  32'(bus.data_out),   32'd0);
    check("rst_ovf",   32'(bus.overflow),   32'd0);
    check("rst_unf",   32'(bus.underflow),  32'd0);
    bus.insert = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_count", 32'(bus.count), 32'd0);

    // 2: basic ordering
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("t2_count", 32'(bus.count), 32'd3);
    pop_chk("t2_pop0");
    pop_chk("t2_pop1");
    pop_chk("t2_pop2");
    check("t2_empty", 32'(bus.empty), 32'd1);
    tick();
    check("t2_valid_drop", 32'(bus.data_valid), 32'd0);
    check("t2_dout_held",  32'(bus.data_out),   32'h33);

    // 3: fill, overflow, drain
    for (int i = 0; i < D; i++) push(W'(i));
    check("t3_full",  32'(bus.full),  32'd1);
    check("t3_count", 32'(bus.count), 32'd16);
    bus.insert  = 1'b1;
    bus.data_in = 8'hAA;
    tick();
    bus.insert  = 1'b0;
`ifdef RX_FIFO_OVERWRITE_EN
    void'(exp_q.pop_front());
    exp_q.push_back(8'hAA);
`endif
    check("t3_ovf",       32'(bus.overflow), 32'd1);
    check("t3_ovf_count", 32'(bus.count),    32'd16);
    tick();
    check("t3_ovf_drop",  32'(bus.overflow), 32'd0);
    for (int i = 0; i < D; i++) pop_chk($sformatf("t3_drain%0d", i));
    check("t3_empty", 32'(bus.empty), 32'd1);

    // 4: underflow, then insert+remove on empty
    bus.remove = 1'b1;
    tick();
    bus.remove = 1'b0;
    check("t4_unf",      32'(bus.underflow),  32'd1);
    check("t4_unf_vld",  32'(bus.data_valid), 32'd0);
    check("t4_unf_dout", 32'(bus.data_out),   32'(last_out));
    bus.insert  = 1'b1;
    bus.remove  = 1'b1;
    bus.data_in = 8'h77;
    tick();
    bus.insert  = 1'b0;
    bus.remove  = 1'b0;
    exp_q.push_back(8'h77);
    check("t4_ir_count", 32'(bus.count),      32'd1);
    check("t4_ir_unf",   32'(bus.underflow),  32'd1);
    check("t4_ir_vld",   32'(bus.data_valid), 32'd0);
    pop_chk("t4_pop");

    // 5: wrap and simultaneous insert+remove at full
    for (int i = 0; i < 12; i++) push(8'h40 + W'(i));
    for (int i = 0; i < 12; i++) pop_chk($sformatf("t5_a%0d", i));
    for (int i = 0; i < 10; i++) push(8'h60 + W'(i));
    check("t5_count10", 32'(bus.count), 32'd10);
    for (int i = 0; i < 6; i++) push(8'h80 + W'(i));
    check("t5_full", 32'(bus.full), 32'd1);
    bus.insert  = 1'b1;
    bus.remove  = 1'b1;
    bus.data_in = 8'hEE;
    tick();
    bus.insert  = 1'b0;
    bus.remove  = 1'b0;
    last_out = exp_q.pop_front();
    exp_q.push_back(8'hEE);
    check("t5_ir_data",  32'(bus.data_out),   32'(last_out));
    check("t5_ir_valid", 32'(bus.data_valid), 32'd1);
    check("t5_ir_count", 32'(bus.count),      32'd16);
    check("t5_ir_ovf",   32'(bus.overflow),   32'd0);
    for (int i = 0; i < D; i++) pop_chk($sformatf("t5_d%0d", i));
    check("t5_empty", 32'(bus.empty), 32'd1);

    // 6: clear beats insert+remove
    for (int i = 0; i < 5; i++) push(8'hC0 + W'(i));
    check("t6_count5", 32'(bus.count), 32'd5);
    bus.clear   = 1'b1;
    bus.insert  = 1'b1;
    bus.remove  = 1'b1;
    bus.data_in = 8'h55;
    tick();
    bus.clear   = 1'b0;
    bus.insert  = 1'b0;
    bus.remove  = 1'b0;
    exp_q.delete();
    check("t6_count", 32'(bus.count),      32'd0);
    check("t6_empty", 32'(bus.empty),      32'd1);
    check("t6_ovf",   32'(bus.overflow),   32'd0);
    check("t6_unf",   32'(bus.underflow),  32'd0);
    check("t6_vld",   32'(bus.data_valid), 32'd0);
    check("t6_dout",  32'(bus.data_out),   32'(last_out));
    push(8'h99);
    pop_chk("t6_after");
    check("t6_end_empty", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
